// File: rtl/design1_bist_pkg.sv
// Shared types and constants for the design1 BIST wrapper: FSM states,
// LFSR/MISR widths and tap masks, and the LFSR step used to walk input vectors.
package design1_bist_pkg;

  localparam int LFSR_W = 14;
  localparam int MISR_W = 8;

  // Tap masks: LFSR feedback from bits 13,4,2,0; MISR feedback from bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 14'h2015;
  localparam logic [MISR_W-1:0] MISR_TAPS     = 8'hB8;
  localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 14'h0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/design1_bist_ctrl_misr.sv
// 8-bit multiple-input signature register; clear wins over enable.
module bist_misr
  import design1_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [MISR_W-1:0] d,
  output logic [MISR_W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      sig <= '0;
    else if (en)
      sig <= {sig[MISR_W-2:0], ^(sig & MISR_TAPS)} ^ d;
  end

endmodule

// File: rtl/design1_bist_ctrl.sv
// BIST wrapper around the design1 cone: LFSR vector generator, optional response
// capture stage and MISR compaction, sequenced by a four-state FSM.
module design1_bist_ctrl
  import design1_bist_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  num_vec,
  output logic [LFSR_W-1:0] dut_in,
  input  logic [MISR_W-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature
);

  localparam int STAGES = (OUT_REG != 0) ? 1 : 0;

  bist_state_e       state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [LFSR_W-1:0] dut_in_nxt;
  logic              accept;
  logic              run_vld;
  logic [STAGES:0]   vld_pipe;
  logic              misr_en;
  logic [MISR_W-1:0] misr_d;

  assign accept  = (state == IDLE) && start;
  assign run_vld = (state == RUN);
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      dut_in <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      dut_in <= dut_in_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    dut_in_nxt = dut_in;
    case (state)
      IDLE: if (start) begin
        count_nxt  = num_vec;
        dut_in_nxt = (seed == '0) ? SEED_ZERO_SUB : seed;
        state_nxt  = (num_vec == '0) ? DONE : RUN;
      end
      RUN: begin
        count_nxt = count - CNT_W'(1);
        // The last vector stays on the cone so its response can still be captured
        if (count == CNT_W'(1))
          state_nxt = (OUT_REG != 0) ? DRAIN : DONE;
        else
          dut_in_nxt = lfsr_next(dut_in);
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The valid bit follows the response to the MISR, so the capture stage's first
  // (empty) slot is skipped and the DRAIN cycle absorbs the last captured value.
  generate
    if (OUT_REG != 0) begin : g_cap
      logic              cap_vld;
      logic [MISR_W-1:0] cap_q;

      always_ff @(posedge clk) begin
        if (rst || accept) begin
          cap_vld <= 1'b0;
          cap_q   <= '0;
        end else begin
          cap_vld <= run_vld;
          if (run_vld)
            cap_q <= dut_out;
        end
      end

      assign vld_pipe = {cap_vld, run_vld};
      assign misr_d   = cap_q;
    end else begin : g_direct
      assign vld_pipe = run_vld;
      assign misr_d   = dut_out;
    end
  endgenerate

  assign misr_en = vld_pipe[STAGES];

  bist_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (misr_en),
    .d   (misr_d),
    .sig (signature)
  );

endmodule
